// File: rtl/trg_pkg.sv
// Shared constants and types for the trigger-source front end.
package trg_pkg;

    localparam int SRC_COINCID  = 0;
    localparam int SRC_EXT      = 1;
    localparam int SRC_CYC      = 2;
    localparam int SRC_N        = 3;
    localparam int TRG_CNT_W    = 16;
    localparam int CYC_PERIOD_W = 16;

    typedef enum logic {
        CYC_IDLE = 1'b0,
        CYC_RUN  = 1'b1
    } cyc_state_e;

endpackage

// File: rtl/trg_src_gen_if.sv
// Bundle between the trigger controller side (master) and the trigger-source front end (slave).
interface trg_src_gen_if import trg_pkg::*; #(
    parameter int CNT_W = TRG_CNT_W
) ();

    logic                    coincid_raw_in;
    logic                    ext_trg_in;
    logic [SRC_N-1:0]        src_enb_in;
    logic [CYC_PERIOD_W-1:0] cyc_period_in;
    logic                    eff_trg_in;
    logic                    daq_busy_in;
    logic                    cnt_clr_in;
    logic                    coincid_trg_out;
    logic                    ext_trg_syn_out;
    logic                    cycled_trg_out;
    logic [CNT_W-1:0]        eff_trg_cnt_out;
    logic [CNT_W-1:0]        lost_trg_cnt_out;

    modport master (
        output coincid_raw_in, ext_trg_in, src_enb_in, cyc_period_in,
               eff_trg_in, daq_busy_in, cnt_clr_in,
        input  coincid_trg_out, ext_trg_syn_out, cycled_trg_out,
               eff_trg_cnt_out, lost_trg_cnt_out
    );

    modport slave (
        input  coincid_raw_in, ext_trg_in, src_enb_in, cyc_period_in,
               eff_trg_in, daq_busy_in, cnt_clr_in,
        output coincid_trg_out, ext_trg_syn_out, cycled_trg_out,
               eff_trg_cnt_out, lost_trg_cnt_out
    );

endinterface

// File: rtl/trg_ext_sync_filter.sv
// External trigger: 2-FF synchroniser, run-length filter and single pulse per accepted high level.
module trg_ext_sync_filter #(
    parameter int EXT_FILT_LEN = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic ext_trg_in,
    input  logic enb_in,
    output logic trg_out
);

    localparam int             FW       = $clog2(EXT_FILT_LEN + 1);
    localparam logic [FW-1:0]  FILT_MAX = FW'(EXT_FILT_LEN);
    localparam logic [FW-1:0]  FILT_ARM = FW'(EXT_FILT_LEN - 1);

    logic          s1_q;
    logic          s2_q;
    logic [FW-1:0] filt_q;
    logic          trg_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= '0;
            trg_q  <= 1'b0;
        end else begin
            s1_q <= ext_trg_in;
            s2_q <= s1_q;
            // Saturating at FILT_MAX keeps the pulse to one per high level.
            if (!s2_q)
                filt_q <= '0;
            else if (filt_q != FILT_MAX)
                filt_q <= filt_q + 1'b1;
            trg_q <= s2_q && (filt_q == FILT_ARM) && enb_in;
        end
    end

    assign trg_out = trg_q;

endmodule

// File: rtl/trg_src_gen.sv
// Trigger-source front end: coincidence edge pulse, filtered external pulse, periodic
// pulse generator, effective-trigger ID counter and saturating lost-trigger counter.
module trg_src_gen import trg_pkg::*; #(
    parameter int EXT_FILT_LEN  = 4,
    parameter int CYC_STEP_LOG2 = 8,
    parameter int CNT_W         = TRG_CNT_W
) (
    input  logic         clk_in,
    input  logic         rst_in,
    trg_src_gen_if.slave trg_if
);

    localparam int               PH_W    = CYC_PERIOD_W + CYC_STEP_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                    coincid_prev_q;
    logic                    coincid_trg_q;
    logic                    ext_trg_syn;
    cyc_state_e              cyc_state_q;
    logic [CYC_PERIOD_W-1:0] cyc_period_q;
    logic [PH_W-1:0]         cyc_phase_q;
    logic                    cycled_trg_q;
    logic [CNT_W-1:0]        eff_cnt_q;
    logic [CNT_W-1:0]        lost_cnt_q;
    logic [PH_W-1:0]         cyc_term;
    logic                    cyc_req;
    logic                    any_trg;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            coincid_prev_q <= 1'b0;
            coincid_trg_q  <= 1'b0;
        end else begin
            coincid_prev_q <= trg_if.coincid_raw_in;
            coincid_trg_q  <= trg_if.coincid_raw_in && !coincid_prev_q
                              && trg_if.src_enb_in[SRC_COINCID];
        end
    end

    trg_ext_sync_filter #(
        .EXT_FILT_LEN (EXT_FILT_LEN)
    ) u_ext_filt (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .ext_trg_in (trg_if.ext_trg_in),
        .enb_in     (trg_if.src_enb_in[SRC_EXT]),
        .trg_out    (ext_trg_syn)
    );

    assign cyc_req  = trg_if.src_enb_in[SRC_CYC] && (trg_if.cyc_period_in != '0);
    assign cyc_term = {cyc_period_q, {CYC_STEP_LOG2{1'b0}}} - PH_W'(1);

    // The period is only re-latched at wrap, so a change takes effect one period later.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cyc_state_q  <= CYC_IDLE;
            cyc_period_q <= '0;
            cyc_phase_q  <= '0;
            cycled_trg_q <= 1'b0;
        end else begin
            cycled_trg_q <= 1'b0;
            case (cyc_state_q)
                CYC_IDLE: begin
                    cyc_phase_q <= '0;
                    if (cyc_req) begin
                        cyc_state_q  <= CYC_RUN;
                        cyc_period_q <= trg_if.cyc_period_in;
                    end
                end
                CYC_RUN: begin
                    if (!cyc_req) begin
                        cyc_state_q <= CYC_IDLE;
                        cyc_phase_q <= '0;
                    end else if (cyc_phase_q == cyc_term) begin
                        cycled_trg_q <= 1'b1;
                        cyc_phase_q  <= '0;
                        cyc_period_q <= trg_if.cyc_period_in;
                    end else begin
                        cyc_phase_q <= cyc_phase_q + 1'b1;
                    end
                end
                default: cyc_state_q <= CYC_IDLE;
            endcase
        end
    end

    assign any_trg = coincid_trg_q || ext_trg_syn || cycled_trg_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            eff_cnt_q  <= '0;
            lost_cnt_q <= '0;
        end else if (trg_if.cnt_clr_in) begin
            eff_cnt_q  <= '0;
            lost_cnt_q <= '0;
        end else begin
            if (trg_if.eff_trg_in)
                eff_cnt_q <= eff_cnt_q + 1'b1;
            if (any_trg && trg_if.daq_busy_in && lost_cnt_q != CNT_MAX)
                lost_cnt_q <= lost_cnt_q + 1'b1;
        end
    end

    assign trg_if.coincid_trg_out  = coincid_trg_q;
    assign trg_if.ext_trg_syn_out  = ext_trg_syn;
    assign trg_if.cycled_trg_out   = cycled_trg_q;
    assign trg_if.eff_trg_cnt_out  = eff_cnt_q;
    assign trg_if.lost_trg_cnt_out = lost_cnt_q;

endmodule

// File: tb/tb_trg_src_gen.sv
// Scoreboard bench for trg_src_gen: stimulus pushes expected pulse cycles, a negedge monitor checks.
module tb_trg_src_gen;

    // Narrow counters so wrap and saturation are reached in a few thousand cycles.
    localparam int               CNT_W   = 10;
    localparam int               EXT_LEN = 4;
    localparam int               STEP    = 256;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int   coin_q[$];
    int   ext_q[$];
    int   cyc_q[$];
    int   m_eff = 0;
    int   m_lost = 0;
    bit   ec, ee, ey;
    int   c0;

    trg_src_gen_if #(.CNT_W(CNT_W)) bus ();

    trg_src_gen #(
        .EXT_FILT_LEN  (EXT_LEN),
        .CYC_STEP_LOG2 (8),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .trg_if (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pulses are compared against queued expected cycles, counters against the model.
    always @(negedge clk) begin
        if (rst) begin
            m_eff  = 0;
            m_lost = 0;
        end
        ec = (coin_q.size() > 0) && (coin_q[0] == cyc);
        ee = (ext_q.size()  > 0) && (ext_q[0]  == cyc);
        ey = (cyc_q.size()  > 0) && (cyc_q[0]  == cyc);
        if (ec || bus.coincid_trg_out) check("coincid_pulse", 32'(bus.coincid_trg_out), 32'(ec));
        if (ee || bus.ext_trg_syn_out) check("ext_pulse", 32'(bus.ext_trg_syn_out), 32'(ee));
        if (ey || bus.cycled_trg_out)  check("cycled_pulse", 32'(bus.cycled_trg_out), 32'(ey));
        if (ec) void'(coin_q.pop_front());
        if (ee) void'(ext_q.pop_front());
        if (ey) void'(cyc_q.pop_front());
        check("eff_cnt", 32'(bus.eff_trg_cnt_out), 32'(m_eff));
        check("lost_cnt", 32'(bus.lost_trg_cnt_out), 32'(m_lost));
        if (!rst) begin
            if (bus.cnt_clr_in) begin
                m_eff  = 0;
                m_lost = 0;
            end else begin
                if (bus.eff_trg_in) m_eff = (m_eff + 1) % (1 << CNT_W);
                if ((ec || ee || ey) && bus.daq_busy_in && m_lost < int'(CNT_MAX)) m_lost++;
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.coincid_raw_in = 1'b0;
        bus.ext_trg_in     = 1'b0;
        bus.src_enb_in     = 3'b000;
        bus.cyc_period_in  = 16'd0;
        bus.eff_trg_in     = 1'b0;
        bus.daq_busy_in    = 1'b0;
        bus.cnt_clr_in     = 1'b0;
        step(3);
        check("rst_coincid", 32'(bus.coincid_trg_out), 0);
        check("rst_ext", 32'(bus.ext_trg_syn_out), 0);
        check("rst_cycled", 32'(bus.cycled_trg_out), 0);
        check("rst_eff", 32'(bus.eff_trg_cnt_out), 0);
        check("rst_lost", 32'(bus.lost_trg_cnt_out), 0);
        rst = 1'b0;
        step(5);

        // Coincidence: random levels, enables, busy, eff pulses and occasional clears.
        for (int i = 0; i < 40; i++) begin
            bus.src_enb_in     = 3'($urandom_range(0, 7));
            bus.daq_busy_in    = 1'($urandom_range(0, 1));
            bus.eff_trg_in     = 1'($urandom_range(0, 1));
            bus.cnt_clr_in     = ($urandom_range(0, 9) == 0);
            bus.coincid_raw_in = 1'b1;
            if (bus.src_enb_in[0]) coin_q.push_back(cyc + 1);
            step($urandom_range(1, 5));
            bus.cnt_clr_in     = 1'b0;
            bus.coincid_raw_in = 1'b0;
            step($urandom_range(1, 3));
        end
        bus.eff_trg_in = 1'b0;

        // External: a 3-clk glitch, a 10-clk level, then random run lengths.
        for (int i = 0; i < 22; i++) begin
            int len;
            len = (i == 0) ? 3 : (i == 1) ? 10 : $urandom_range(1, 8);
            bus.src_enb_in  = (i < 2) ? 3'b010 : 3'($urandom_range(0, 7));
            bus.daq_busy_in = 1'($urandom_range(0, 1));
            bus.ext_trg_in  = 1'b1;
            if (len >= EXT_LEN && bus.src_enb_in[1]) ext_q.push_back(cyc + EXT_LEN + 2);
            step(len);
            bus.ext_trg_in = 1'b0;
            step(6 + $urandom_range(0, 3));
        end

        // Coincidence and external pulses in the same clock while busy.
        bus.src_enb_in  = 3'b011;
        bus.daq_busy_in = 1'b1;
        bus.ext_trg_in  = 1'b1;
        ext_q.push_back(cyc + EXT_LEN + 2);
        step(EXT_LEN + 1);
        bus.coincid_raw_in = 1'b1;
        coin_q.push_back(cyc + 1);
        step(6);
        bus.ext_trg_in     = 1'b0;
        bus.coincid_raw_in = 1'b0;
        bus.daq_busy_in    = 1'b0;
        step(8);

        // All sources disabled, then coincidence enabled while already high.
        bus.src_enb_in     = 3'b000;
        bus.coincid_raw_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.ext_trg_in = 1'b1;
            step(6);
            bus.ext_trg_in = 1'b0;
            step(3);
        end
        bus.src_enb_in = 3'b001;
        step(5);
        bus.coincid_raw_in = 1'b0;
        step(2);
        bus.coincid_raw_in = 1'b1;
        coin_q.push_back(cyc + 1);
        step(3);
        bus.coincid_raw_in = 1'b0;
        step(3);

        // Lost counter saturation.
        bus.daq_busy_in = 1'b1;
        for (int i = 0; i < int'(CNT_MAX) + 80; i++) begin
            bus.coincid_raw_in = 1'b1;
            coin_q.push_back(cyc + 1);
            step(1);
            bus.coincid_raw_in = 1'b0;
            step(1);
        end
        step(2);
        check("lost_saturated", 32'(bus.lost_trg_cnt_out), 32'(CNT_MAX));
        bus.daq_busy_in = 1'b0;
        bus.cnt_clr_in  = 1'b1;
        step(1);
        bus.cnt_clr_in = 1'b0;
        step(1);
        check("lost_cleared", 32'(bus.lost_trg_cnt_out), 0);

        // Effective counter: preload to all-ones, wrap, then clear beating increment.
        bus.eff_trg_in = 1'b1;
        step(int'(CNT_MAX));
        bus.eff_trg_in = 1'b0;
        step(1);
        check("eff_preload", 32'(bus.eff_trg_cnt_out), 32'(CNT_MAX));
        bus.eff_trg_in = 1'b1;
        step(1);
        bus.eff_trg_in = 1'b0;
        step(1);
        check("eff_wrap", 32'(bus.eff_trg_cnt_out), 0);
        bus.eff_trg_in = 1'b1;
        step(3);
        bus.cnt_clr_in = 1'b1;
        step(1);
        bus.cnt_clr_in = 1'b0;
        bus.eff_trg_in = 1'b0;
        step(1);
        check("eff_clr_wins", 32'(bus.eff_trg_cnt_out), 0);

        // Cycled: period 2, changed to 1 mid-period, then disabled.
        bus.src_enb_in    = 3'b100;
        bus.cyc_period_in = 16'd2;
        c0 = cyc;
        cyc_q.push_back(c0 + 1 + 2 * STEP);
        cyc_q.push_back(c0 + 1 + 4 * STEP);
        cyc_q.push_back(c0 + 1 + 5 * STEP);
        cyc_q.push_back(c0 + 1 + 6 * STEP);
        step(600);
        bus.cyc_period_in = 16'd1;
        step(1000);
        bus.src_enb_in = 3'b000;
        step(10);

        // Reset mid-period discards phase; first pulse a full period after release.
        bus.src_enb_in = 3'b100;
        bus.eff_trg_in = 1'b1;
        step(5);
        bus.eff_trg_in = 1'b0;
        step(95);
        rst = 1'b1;
        step(1);
        check("rst_mid_cycled", 32'(bus.cycled_trg_out), 0);
        check("rst_mid_eff", 32'(bus.eff_trg_cnt_out), 0);
        check("rst_mid_lost", 32'(bus.lost_trg_cnt_out), 0);
        step(2);
        rst = 1'b0;
        cyc_q.push_back(cyc + 1 + STEP);
        step(300);
        bus.src_enb_in = 3'b000;
        step(20);

        check("coin_q_drained", coin_q.size(), 0);
        check("ext_q_drained", ext_q.size(), 0);
        check("cyc_q_drained", cyc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
